// File: rtl/win_mul_seq.sv
// win_mul_seq: sequential signed multiplier using shift-and-add on operand
// magnitudes, with the sign applied in a final step.
// Handshaked input (in_valid/in_ready) and output (out_valid/out_ready).
// Optional macro WIN_MUL_EARLY_EXIT_EN: when defined, CALC also finishes as
// soon as the remaining multiplier magnitude is zero. This shortens latency
// and does not change the product.
module win_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mul_a,
    input  logic [WIDTH-1:0]     mul_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul_out,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_a_q;
    logic [WIDTH-1:0]     mag_b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic [2*WIDTH-1:0]   mul_out_q;

    logic                 accept;
    logic                 calc_exit;
    logic [2*WIDTH-1:0]   ext_a;

    // Two's-complement magnitude. The most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    assign accept = in_valid && (state_q == S_IDLE);
    assign ext_a  = {{WIDTH{1'b0}}, mag_a_q};

`ifdef WIN_MUL_EARLY_EXIT_EN
    assign calc_exit = (cnt_q == CW'(WIDTH)) || (mag_b_q == '0);
`else
    assign calc_exit = (cnt_q == CW'(WIDTH));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)    state_d = S_CALC;
            S_CALC: if (calc_exit) state_d = S_SIGN;
            S_SIGN:                state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture magnitudes, shift-and-add, then apply the sign once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            mul_out_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        mag_a_q <= magnitude(mul_a);
                        mag_b_q <= magnitude(mul_b);
                        sign_q  <= mul_a[WIDTH-1] ^ mul_b[WIDTH-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_CALC: begin
                    if (!calc_exit) begin
                        if (mag_b_q[0]) begin
                            acc_q <= acc_q + (ext_a << cnt_q);
                        end
                        mag_b_q <= mag_b_q >> 1;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                S_SIGN: begin
                    // A zero accumulator is emitted as plain zero whatever the sign.
                    if (sign_q && (acc_q != '0)) begin
                        mul_out_q <= ~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        mul_out_q <= acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_out = mul_out_q;

endmodule

// File: tb/tb_win_mul_seq.sv
// Testbench for win_mul_seq (WIDTH=8). It runs directed vectors with latency
// and stall checks, a reset in the middle of an operation, and a random
// handshaked stream checked against a signed-arithmetic reference model.
module tb_win_mul_seq;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  mul_a = '0;
    logic [W-1:0]  mul_b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [2*W-1:0] mul_out;

    int errors = 0;
    int checks = 0;

    win_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mul_out   (mul_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: plain signed integer multiplication, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int pa;
        int pb;
        pa = int'($signed(a));
        pb = int'($signed(b));
        return (2*W)'(pa * pb);
    endfunction

    // Reference latency, in cycles from the accept edge to out_valid rising.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef WIN_MUL_EARLY_EXIT_EN
        int m;
        int n;
        m = int'($signed(b));
        if (m < 0) m = -m;
        n = 0;
        while (m > 0) begin
            m = m >> 1;
            n++;
        end
        return 2 + n;
`else
        return W + 2;
`endif
    endfunction

    // One complete operation: accept, latency, product, optional stall, handshake.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int hold);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        mul_a = a;
        mul_b = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mul_a = W'($urandom);
        mul_b = W'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            mul_a = W'($urandom);
            mul_b = W'($urandom);
        end
        $display("op %s: a=%0h b=%0h mul_out=%0h latency=%0d", tag, a, b, mul_out, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat(b)));
        check({tag, "_product"}, 32'(mul_out), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_data"}, 32'(mul_out), 32'(exp));
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_hold"}, 32'(mul_out), 32'(exp));
    endtask

    initial begin
        logic [2*W-1:0] q[$];
        logic [2*W-1:0] expv;
        int sent;
        int got;
        int cyc;
        int seen;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul_out", 32'(mul_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        run_op("v3xm5",     8'h03, 8'hFB, 16'hFFF1, 0);
        run_op("vm128sq",   8'h80, 8'h80, 16'h4000, 0);
        run_op("v127xm128", 8'h7F, 8'h80, 16'hC080, 0);
        run_op("v0xm7",     8'h00, 8'hF9, 16'h0000, 0);
        run_op("vm3x0",     8'hFD, 8'h00, 16'h0000, 0);
        run_op("vm3x1",     8'hFD, 8'h01, 16'hFFFD, 0);
        run_op("stall",     8'h09, 8'hF7, 16'hFFAF, 5);

        // Reset in the middle of CALC (cnt=4) discards the operation
        mul_a = 8'h05;
        mul_b = 8'h07;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mul_out", 32'(mul_out), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        run_op("after_rst", 8'h02, 8'h02, 16'h0004, 0);

        // Random handshaked stream against the reference model
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
            in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            mul_a     = W'($urandom);
            mul_b     = W'($urandom);
            out_ready = ($urandom_range(2) != 0);
            if (in_valid && in_ready) begin
                q.push_back(ref_prod(mul_a, mul_b));
                sent++;
            end
            if (out_valid && out_ready) begin
                check("stream_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    expv = q.pop_front();
                    check("stream_product", 32'(mul_out), 32'(expv));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        $display("stream: sent=%0d received=%0d cycles=%0d", sent, got, cyc);
        check("stream_count", 32'(got), 32'd1000);
        check("stream_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
